uart_mag_frame_rx: RTL and testbench

Receive-side parser for the Goertzel magnitude telemetry frame that the tone detector transmits over UART. It consumes the byte stream from the uart_controller RX path (RX_DATA / RX_DATA_READY) and reassembles the run index and both 16-bit magnitudes. Valid frames are presented on a registered output bank with a one-cycle strobe; malformed frames are reported and the parser resynchronises. It is used on the loopback/second-board side, and for self-test of the TX framing.

---
 rtl/uart_mag_frame_rx_pkg.sv | 23 ++
 rtl/uart_mag_frame_rx_if.sv | 25 ++
 rtl/uart_mag_frame_rx_ctr.sv | 27 ++
 rtl/uart_mag_frame_rx.sv | 124 ++++++++++++
 tb/tb_uart_mag_frame_rx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mag_frame_rx_pkg.sv
// Shared framing constants for the Goertzel magnitude telemetry link (RX parser and TX sequencer).
package uart_frame_pkg;

    localparam logic [7:0] COMMA = 8'h2C;
    localparam logic [7:0] TERM  = 8'h0A;

    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_C0   = 3'd1;
    localparam logic [2:0] S_G0L  = 3'd2;
    localparam logic [2:0] S_G0H  = 3'd3;
    localparam logic [2:0] S_C1   = 3'd4;
    localparam logic [2:0] S_G1L  = 3'd5;
    localparam logic [2:0] S_G1H  = 3'd6;
    localparam logic [2:0] S_TERM = 3'd7;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RUN   = 2'd1,
        ERR_DELIM = 2'd2,
        ERR_TMO   = 2'd3
    } err_code_t;

endpackage

// File: rtl/uart_mag_frame_rx_if.sv
// Byte-stream input and decoded-frame output bundle of the magnitude frame parser.
interface uart_mag_frame_rx_if;

    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic [4:0]  run_out;
    logic [15:0] g0;
    logic [15:0] g1;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [7:0]  err_count;

    modport master (
        output rx_data, rx_data_ready,
        input  run_out, g0, g1, frame_valid, frame_err, err_code, busy, err_count
    );

    modport slave (
        input  rx_data, rx_data_ready,
        output run_out, g0, g1, frame_valid, frame_err, err_code, busy, err_count
    );

endinterface

// File: rtl/uart_mag_frame_rx_ctr.sv
// Inter-byte timeout counter; expired is combinational so the parser can abort on the same edge.
module frame_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A strobe in the expiry cycle clears instead, so the byte wins.
    assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_mag_frame_rx.sv
// Positional parser for RUN,COMMA,G0L,G0H,COMMA,G1L,G1H,TERM frames with registered output bank.
module uart_mag_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input  logic               sys_clk,
    input  logic               rst,
    uart_mag_frame_rx_if.slave bus
);
    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [4:0]  sh_run;
    logic [15:0] sh_g0;
    logic [15:0] sh_g1;
    logic        do_abort;
    logic        do_commit;
    logic        tmo_expired;
    logic        busy;
    err_code_t   abort_code;

    assign busy     = (state != S_RUN);
    assign bus.busy = busy;

    frame_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (bus.rx_data_ready || !busy),
        .en      (busy),
        .expired (tmo_expired)
    );

    always_comb begin
        next_state = state;
        do_abort   = 1'b0;
        do_commit  = 1'b0;
        abort_code = ERR_NONE;
        if (bus.rx_data_ready) begin
            case (state)
                S_RUN: begin
                    if (bus.rx_data[7:5] == 3'b000) begin
                        next_state = S_C0;
                    end else begin
                        do_abort   = 1'b1;
                        abort_code = ERR_RUN;
                    end
                end
                S_C0, S_C1: begin
                    if (bus.rx_data == COMMA) begin
                        next_state = (state == S_C0) ? S_G0L : S_G1L;
                    end else begin
                        do_abort   = 1'b1;
                        abort_code = ERR_DELIM;
                    end
                end
                S_G0L: next_state = S_G0H;
                S_G0H: next_state = S_C1;
                S_G1L: next_state = S_G1H;
                S_G1H: next_state = S_TERM;
                S_TERM: begin
                    if (bus.rx_data == TERM) begin
                        do_commit  = 1'b1;
                        next_state = S_RUN;
                    end else begin
                        do_abort   = 1'b1;
                        abort_code = ERR_DELIM;
                    end
                end
                default: next_state = S_RUN;
            endcase
        end else if (tmo_expired) begin
            do_abort   = 1'b1;
            abort_code = ERR_TMO;
        end
        // Offending byte is dropped, never re-parsed as a RUN byte.
        if (do_abort) begin
            next_state = S_RUN;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state           <= S_RUN;
            sh_run          <= '0;
            sh_g0           <= '0;
            sh_g1           <= '0;
            bus.run_out     <= '0;
            bus.g0          <= '0;
            bus.g1          <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.err_code    <= '0;
            bus.err_count   <= '0;
        end else begin
            state           <= next_state;
            bus.frame_valid <= do_commit;
            bus.frame_err   <= do_abort;
            if (bus.rx_data_ready) begin
                case (state)
                    S_RUN:   if (!do_abort) sh_run <= bus.rx_data[4:0];
                    S_G0L:   sh_g0[7:0]  <= bus.rx_data;
                    S_G0H:   sh_g0[15:8] <= bus.rx_data;
                    S_G1L:   sh_g1[7:0]  <= bus.rx_data;
                    S_G1H:   sh_g1[15:8] <= bus.rx_data;
                    default: ;
                endcase
            end
            if (do_commit) begin
                bus.run_out <= sh_run;
                bus.g0      <= sh_g0;
                bus.g1      <= sh_g1;
            end
            if (do_abort) begin
                bus.err_code <= abort_code;
                if (bus.err_count != 8'hFF) begin
                    bus.err_count <= bus.err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_mag_frame_rx.sv
// Table- and scoreboard-driven bench for the magnitude frame parser.
module tb_uart_mag_frame_rx;

    localparam int T = 16;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          gap;
        bit          is_err;
        logic [1:0]  code;
        logic [4:0]  run;
        logic [15:0] g0;
        logic [15:0] g1;
    } vec_t;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [1:0]  code;
        logic [7:0]  cnt;
        logic [4:0]  run;
        logic [15:0] g0;
        logic [15:0] g1;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    exp_t        sb[$];
    vec_t        tbl[8];
    logic [4:0]  exp_run  = '0;
    logic [15:0] exp_g0   = '0;
    logic [15:0] exp_g1   = '0;
    logic [1:0]  exp_code = '0;
    int          exp_cnt  = 0;

    uart_mag_frame_rx_if bus ();

    uart_mag_frame_rx #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [63:0] b, input int n, input int gap, input bit e,
                                input logic [1:0] c, input logic [4:0] r,
                                input logic [15:0] a, input logic [15:0] d);
        vec_t v;
        v.bytes = b; v.n = n; v.gap = gap; v.is_err = e;
        v.code = c; v.run = r; v.g0 = a; v.g1 = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.rx_data_ready = 1'b0;
        bus.rx_data       = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Called just before the strobe that completes or breaks a frame.
    task automatic push(input bit e, input logic [1:0] c, input logic [4:0] r,
                        input logic [15:0] a, input logic [15:0] d);
        exp_t x;
        if (e) begin
            exp_code = c;
            if (exp_cnt != 255) exp_cnt++;
        end else begin
            exp_run = r; exp_g0 = a; exp_g1 = d;
        end
        x.is_err = e; x.cyc = cyc + 1; x.code = exp_code; x.cnt = exp_cnt[7:0];
        x.run = exp_run; x.g0 = exp_g0; x.g1 = exp_g1;
        sb.push_back(x);
    endtask

    task automatic send_frame(input logic [4:0] r, input logic [15:0] a, input logic [15:0] d);
        strobe({3'b000, r}); strobe(8'h2C); strobe(a[7:0]); strobe(a[15:8]);
        strobe(8'h2C); strobe(d[7:0]); strobe(d[15:8]);
        push(1'b0, 2'd0, r, a, d);
        strobe(8'h0A);
    endtask

    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_vec++; n_bad++;
            $display("FAIL missing_strobe: got no strobe, want %s at cycle %0d",
                     sb[0].is_err ? "frame_err" : "frame_valid", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (bus.frame_valid || bus.frame_err) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b, want none (cycle %0d)",
                         bus.frame_valid, bus.frame_err, cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (bus.frame_err !== x.is_err || bus.frame_valid !== !x.is_err || cyc != x.cyc ||
                    bus.err_code !== x.code || bus.err_count !== x.cnt || bus.run_out !== x.run ||
                    bus.g0 !== x.g0 || bus.g1 !== x.g1) begin
                    n_bad++;
                    $display("FAIL frame: got v=%0b e=%0b cyc=%0d code=%0d cnt=%0d run=%h g0=%h g1=%h; want v=%0b e=%0b cyc=%0d code=%0d cnt=%0d run=%h g0=%h g1=%h",
                             bus.frame_valid, bus.frame_err, cyc, bus.err_code, bus.err_count,
                             bus.run_out, bus.g0, bus.g1, !x.is_err, x.is_err, x.cyc, x.code,
                             x.cnt, x.run, x.g0, x.g1);
                end
            end
        end
    end

    initial begin
        tbl[0] = mk(64'h03_2C_34_12_2C_CD_AB_0A, 8, 0, 1'b0, 2'd0, 5'h03, 16'h1234, 16'hABCD);
        tbl[1] = mk(64'h1F_2C_2C_0A_2C_0A_2C_0A, 8, 2, 1'b0, 2'd0, 5'h1F, 16'h0A2C, 16'h2C0A);
        tbl[2] = mk(64'h05_2D_00_00_00_00_00_00, 2, 1, 1'b1, 2'd2, 5'h00, 16'h0000, 16'h0000);
        tbl[3] = mk(64'h11_2C_78_56_2C_21_43_0A, 8, 0, 1'b0, 2'd0, 5'h11, 16'h5678, 16'h4321);
        tbl[4] = mk(64'h80_00_00_00_00_00_00_00, 1, 3, 1'b1, 2'd1, 5'h00, 16'h0000, 16'h0000);
        tbl[5] = mk(64'h02_2C_00_00_2C_00_00_0B, 8, 0, 1'b1, 2'd2, 5'h00, 16'h0000, 16'h0000);
        tbl[6] = mk(64'h07_2C_01_02_03_00_00_00, 5, T - 1, 1'b1, 2'd2, 5'h00, 16'h0000, 16'h0000);
        tbl[7] = mk(64'h0A_2C_FF_FF_2C_00_80_0A, 8, 0, 1'b0, 2'd0, 5'h0A, 16'hFFFF, 16'h8000);

        bus.rx_data       = 8'h00;
        bus.rx_data_ready = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_run", 32'(bus.run_out), 0);
        check("rst_g0", 32'(bus.g0), 0);
        check("rst_g1", 32'(bus.g1), 0);
        check("rst_code", 32'(bus.err_code), 0);
        check("rst_cnt", 32'(bus.err_count), 0);
        check("rst_strobes", 32'({bus.frame_valid, bus.frame_err}), 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < tbl[v].n; i++) begin
                if (i == tbl[v].n - 1)
                    push(tbl[v].is_err, tbl[v].code, tbl[v].run, tbl[v].g0, tbl[v].g1);
                strobe(tbl[v].bytes[63 - 8 * i -: 8]);
                if (tbl[v].gap > 0) idle(tbl[v].gap);
            end
        end
        idle(2);
        check("table_drained", 32'(sb.size()), 0);

        // Timeout: last accepted strobe at cycle P, abort seen after edge P+T.
        strobe(8'h01); strobe(8'h2C);
        check("busy_mid_frame", 32'(bus.busy), 1);
        push(1'b1, 2'd3, 5'h0, 16'h0, 16'h0);
        sb[sb.size() - 1].cyc = cyc + T;
        idle(T + 3);
        check("tmo_busy_cleared", 32'(bus.busy), 0);

        // Next byte lands exactly on the expiry cycle: byte wins.
        strobe(8'h01); strobe(8'h2C);
        idle(T - 1);
        strobe(8'h34); strobe(8'h12); strobe(8'h2C); strobe(8'hCD); strobe(8'hAB);
        push(1'b0, 2'd0, 5'h01, 16'h1234, 16'hABCD);
        strobe(8'h0A);
        idle(2);
        check("expiry_drained", 32'(sb.size()), 0);

        // Reset after byte 4; a strobe during reset must be ignored.
        strobe(8'h01); strobe(8'h2C); strobe(8'h11); strobe(8'h22);
        rst = 1'b1;
        bus.rx_data = 8'h03;
        bus.rx_data_ready = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.rx_data_ready = 1'b0;
        exp_run = '0; exp_g0 = '0; exp_g1 = '0; exp_code = '0; exp_cnt = 0;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_bank", 32'({bus.run_out, bus.g0[10:0], bus.g1}), 0);
        check("midrst_cnt", 32'({bus.err_count, bus.err_code}), 0);
        send_frame(5'h09, 16'hBEEF, 16'hDEAD);

        for (int f = 0; f < 4; f++)
            send_frame(5'(f * 7 + 2), 16'($urandom), 16'($urandom));
        idle(2);
        check("b2b_drained", 32'(sb.size()), 0);

        for (int k = 0; k < 300; k++) begin
            push(1'b1, 2'd1, 5'h0, 16'h0, 16'h0);
            strobe(8'hE0);
        end
        idle(2);
        check("err_saturated", 32'(bus.err_count), 255);
        check("bank_kept_run", 32'(bus.run_out), 32'(exp_run));
        check("bank_kept_g0", 32'(bus.g0), 32'(exp_g0));
        check("final_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
